pong_game_ctrl: RTL and testbench



---
 rtl/pong_pkg.sv | 39 +++
 rtl/pong_game_ctrl_if.sv | 30 +++
 rtl/bcd2_counter.sv | 48 ++++
 rtl/pong_game_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_pong_game_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared definitions for the pong game sequencer.
//   - FSM state encodings (NEWGAME, PLAY, NEWBALL, OVER)
//   - text overlay enable bit indices and per-state patterns
//   - winner codes
//   - helpers to convert a 2-digit BCD score to binary and to
//     increment a binary score with saturation at 99
package pong_pkg;

    typedef enum logic [1:0] {
        NEWGAME = 2'b00,
        PLAY    = 2'b01,
        NEWBALL = 2'b10,
        OVER    = 2'b11
    } state_t;

    localparam int TXT_SCORE = 3;
    localparam int TXT_LOGO  = 2;
    localparam int TXT_RULE  = 1;
    localparam int TXT_OVER  = 0;

    localparam logic [3:0] TXTP_NEWGAME = 4'((1 << TXT_SCORE) | (1 << TXT_LOGO) | (1 << TXT_RULE));
    localparam logic [3:0] TXTP_PLAY    = 4'(1 << TXT_SCORE);
    localparam logic [3:0] TXTP_NEWBALL = 4'(1 << TXT_SCORE);
    localparam logic [3:0] TXTP_OVER    = 4'((1 << TXT_SCORE) | (1 << TXT_OVER));

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_TIE  = 2'b11;

    function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] units);
        return {3'b000, tens} * 7'd10 + {3'b000, units};
    endfunction

    function automatic logic [6:0] bin_inc_sat(input logic [6:0] v);
        return (v >= 7'd99) ? 7'd99 : v + 7'd1;
    endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// pong_game_ctrl_if: bundles the sequencer's game-event inputs and its
// display/graphics outputs.
//   inputs to the controller : btn_start, refresh_tick, score_p1, score_p2
//   outputs of the controller: dig0..dig3, ball, gra_still, text_en, winner, state
// Modports: slave = the controller, master = the surrounding game logic.
interface pong_game_ctrl_if;
    logic       btn_start;
    logic       refresh_tick;
    logic       score_p1;
    logic       score_p2;
    logic [3:0] dig0;
    logic [3:0] dig1;
    logic [3:0] dig2;
    logic [3:0] dig3;
    logic [1:0] ball;
    logic       gra_still;
    logic [3:0] text_en;
    logic [1:0] winner;
    logic [1:0] state;

    modport master (
        output btn_start, refresh_tick, score_p1, score_p2,
        input  dig0, dig1, dig2, dig3, ball, gra_still, text_en, winner, state
    );

    modport slave (
        input  btn_start, refresh_tick, score_p1, score_p2,
        output dig0, dig1, dig2, dig3, ball, gra_still, text_en, winner, state
    );
endinterface

// File: rtl/bcd2_counter.sv
// bcd2_counter: 2-digit BCD up-counter, saturating at 99.
//   clk, reset : clock, asynchronous active-high reset (clears to 00)
//   clr        : synchronous clear to 00 (wins over inc)
//   inc        : increment by one
//   units/tens : BCD digits
module bcd2_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] units,
    output logic [3:0] tens
);
    logic [3:0] units_q, units_d;
    logic [3:0] tens_q, tens_d;

    always_comb begin
        units_d = units_q;
        tens_d  = tens_q;
        if (clr) begin
            units_d = 4'd0;
            tens_d  = 4'd0;
        end else if (inc) begin
            if (units_q == 4'd9) begin
                // At 99 the carry has nowhere to go, so the value holds.
                if (tens_q != 4'd9) begin
                    units_d = 4'd0;
                    tens_d  = tens_q + 4'd1;
                end
            end else begin
                units_d = units_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            units_q <= 4'd0;
            tens_q  <= 4'd0;
        end else begin
            units_q <= units_d;
            tens_q  <= tens_d;
        end
    end

    assign units = units_q;
    assign tens  = tens_q;
endmodule

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: game sequencer for the VGA pong design.
// Owns both players' BCD scores, the balls-remaining count, the post-point
// delay timer and the game-state FSM; drives the text overlay and freezes
// the graphics unit between rallies.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : pong_game_ctrl_if.slave (game events in, display outputs out)
// Parameters: WIN_SCORE (winning score), BALLS (balls per game, 1-3),
//             TIMER_TICKS (post-point delay in frames, 1-127).
// Optional macro PONG_RULE_BLINK_EN: blink the rule overlay in NEWGAME every
// 32 frames; when undefined the rule overlay is steadily on.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE   = 5,
    parameter int BALLS       = 3,
    parameter int TIMER_TICKS = 120
) (
    input  logic             clk,
    input  logic             reset,
    pong_game_ctrl_if.slave  bus
);
    localparam logic [1:0] BALLS_INIT = 2'(BALLS);
    localparam logic [6:0] TIMER_INIT = 7'(TIMER_TICKS);
    localparam logic [6:0] WIN_BIN    = 7'(WIN_SCORE);

    state_t     state_q, state_d;
    logic [1:0] ball_q, ball_d;
    logic       gra_still_q, gra_still_d;
    logic [1:0] winner_q, winner_d;
    logic [6:0] timer_q, timer_d;
    logic       btn_q, btn_d;

    logic       start_ev;
    logic       clr_scores;
    logic       inc_p1, inc_p2;
    logic [3:0] p1_units, p1_tens, p2_units, p2_tens;
    logic [6:0] p1_bin, p2_bin, p1_new, p2_new;
    logic [1:0] ball_dec;
    logic       rule_bit;
    logic [3:0] text_en;

    assign btn_d    = bus.btn_start;
    assign start_ev = bus.btn_start & ~btn_q;
    // Score pulses only count during a rally.
    assign inc_p1   = (state_q == PLAY) & bus.score_p1;
    assign inc_p2   = (state_q == PLAY) & bus.score_p2;

    bcd2_counter u_p1 (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_scores),
        .inc   (inc_p1),
        .units (p1_units),
        .tens  (p1_tens)
    );

    bcd2_counter u_p2 (
        .clk   (clk),
        .reset (reset),
        .clr   (clr_scores),
        .inc   (inc_p2),
        .units (p2_units),
        .tens  (p2_tens)
    );

    // Scores as they will be after this edge, for the win test and winner latch.
    always_comb begin
        p1_bin = bcd_to_bin(p1_tens, p1_units);
        p2_bin = bcd_to_bin(p2_tens, p2_units);
        p1_new = inc_p1 ? bin_inc_sat(p1_bin) : p1_bin;
        p2_new = inc_p2 ? bin_inc_sat(p2_bin) : p2_bin;
    end

    always_comb begin
        state_d     = state_q;
        ball_d      = ball_q;
        gra_still_d = gra_still_q;
        winner_d    = winner_q;
        timer_d     = timer_q;
        clr_scores  = 1'b0;
        ball_dec    = ball_q - 2'd1;
        case (state_q)
            NEWGAME: begin
                if (start_ev) begin
                    state_d     = PLAY;
                    clr_scores  = 1'b1;
                    ball_d      = BALLS_INIT;
                    winner_d    = WIN_NONE;
                    gra_still_d = 1'b0;
                end
            end
            PLAY: begin
                if (inc_p1 | inc_p2) begin
                    ball_d      = ball_dec;
                    gra_still_d = 1'b1;
                    timer_d     = TIMER_INIT;
                    if ((inc_p1 && p1_new == WIN_BIN) || (inc_p2 && p2_new == WIN_BIN) ||
                        ball_dec == 2'd0) begin
                        state_d = OVER;
                        if (p1_new > p2_new)      winner_d = WIN_P1;
                        else if (p2_new > p1_new) winner_d = WIN_P2;
                        else                      winner_d = WIN_TIE;
                    end else begin
                        state_d = NEWBALL;
                    end
                end
            end
            NEWBALL: begin
                if (start_ev && timer_q == 7'd0) begin
                    state_d     = PLAY;
                    gra_still_d = 1'b0;
                end
                if (bus.refresh_tick && timer_q != 7'd0) timer_d = timer_q - 7'd1;
            end
            OVER: begin
                if (timer_q == 7'd0)           state_d = NEWGAME;
                else if (bus.refresh_tick)     timer_d = timer_q - 7'd1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= NEWGAME;
            ball_q      <= BALLS_INIT;
            gra_still_q <= 1'b1;
            winner_q    <= WIN_NONE;
            timer_q     <= 7'd0;
            btn_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ball_q      <= ball_d;
            gra_still_q <= gra_still_d;
            winner_q    <= winner_d;
            timer_q     <= timer_d;
            btn_q       <= btn_d;
        end
    end

`ifdef PONG_RULE_BLINK_EN
    logic [4:0] frame_q, frame_d;
    logic       rule_q, rule_d;

    always_comb begin
        frame_d = frame_q;
        rule_d  = rule_q;
        if (state_d == NEWGAME && state_q != NEWGAME) begin
            frame_d = 5'd0;
            rule_d  = 1'b1;
        end else if (state_q == NEWGAME && bus.refresh_tick) begin
            frame_d = frame_q + 5'd1;
            if (frame_q == 5'd31) rule_d = ~rule_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_q <= 5'd0;
            rule_q  <= 1'b1;
        end else begin
            frame_q <= frame_d;
            rule_q  <= rule_d;
        end
    end

    assign rule_bit = rule_q;
`else
    assign rule_bit = 1'b1;
`endif

    always_comb begin
        text_en = TXTP_PLAY;
        case (state_q)
            NEWGAME: begin
                text_en           = TXTP_NEWGAME;
                text_en[TXT_RULE] = rule_bit;
            end
            PLAY:    text_en = TXTP_PLAY;
            NEWBALL: text_en = TXTP_NEWBALL;
            OVER:    text_en = TXTP_OVER;
        endcase
    end

    assign bus.dig0      = p1_units;
    assign bus.dig1      = p1_tens;
    assign bus.dig2      = p2_units;
    assign bus.dig3      = p2_tens;
    assign bus.ball      = ball_q;
    assign bus.gra_still = gra_still_q;
    assign bus.text_en   = text_en;
    assign bus.winner    = winner_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed self-checking bench for pong_game_ctrl.
// A second controller (WIN_SCORE = 2, TIMER_TICKS = 4) shares the inputs so
// that the win-by-score path is reachable within one game, and a standalone
// bcd2_counter is driven directly to reach the 99 saturation point.
module tb_pong_game_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic b_clr = 1'b0, b_inc = 1'b0;
    logic [3:0] b_u, b_t;
    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pong_game_ctrl_if bus ();
    pong_game_ctrl_if busw ();

    assign busw.btn_start    = bus.btn_start;
    assign busw.refresh_tick = bus.refresh_tick;
    assign busw.score_p1     = bus.score_p1;
    assign busw.score_p2     = bus.score_p2;

    pong_game_ctrl #(.WIN_SCORE(5), .BALLS(3), .TIMER_TICKS(120)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    pong_game_ctrl #(.WIN_SCORE(2), .BALLS(3), .TIMER_TICKS(4)) dut_w (
        .clk(clk), .reset(reset), .bus(busw)
    );

    bcd2_counter bcd_u (
        .clk(clk), .reset(reset), .clr(b_clr), .inc(b_inc), .units(b_u), .tens(b_t)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            bus.refresh_tick = 1'b1; cyc();
            bus.refresh_tick = 1'b0; cyc();
        end
    endtask

    task automatic press_start();
        bus.btn_start = 1'b1; cyc();
        bus.btn_start = 1'b0; cyc();
    endtask

    task automatic score(input logic p1, input logic p2);
        bus.score_p1 = p1; bus.score_p2 = p2; cyc();
        bus.score_p1 = 1'b0; bus.score_p2 = 1'b0;
    endtask

    task automatic test_reset();
        bus.btn_start = 1'b0; bus.refresh_tick = 1'b0; bus.score_p1 = 1'b0; bus.score_p2 = 1'b0;
        reset = 1'b1;
        cyc(); cyc();
        n_tests++; if (bus.state !== 2'b00) begin n_fail++; $display("FAIL reset_state: got %b want 00", bus.state); end
        n_tests++; if ({bus.dig3, bus.dig2, bus.dig1, bus.dig0} !== 16'h0000) begin n_fail++; $display("FAIL reset_digits: got %h want 0000", {bus.dig3, bus.dig2, bus.dig1, bus.dig0}); end
        n_tests++; if (bus.ball !== 2'd3) begin n_fail++; $display("FAIL reset_ball: got %0d want 3", bus.ball); end
        n_tests++; if (bus.gra_still !== 1'b1) begin n_fail++; $display("FAIL reset_gra_still: got %b want 1", bus.gra_still); end
        n_tests++; if (bus.text_en !== 4'b1110) begin n_fail++; $display("FAIL reset_text_en: got %b want 1110", bus.text_en); end
        n_tests++; if (bus.winner !== 2'b00) begin n_fail++; $display("FAIL reset_winner: got %b want 00", bus.winner); end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_start();
        bus.btn_start = 1'b1; cyc();
        n_tests++; if (bus.state !== 2'b01) begin n_fail++; $display("FAIL start_state: got %b want 01", bus.state); end
        n_tests++; if ({bus.dig3, bus.dig2, bus.dig1, bus.dig0} !== 16'h0000) begin n_fail++; $display("FAIL start_digits: got %h want 0000", {bus.dig3, bus.dig2, bus.dig1, bus.dig0}); end
        n_tests++; if (bus.ball !== 2'd3) begin n_fail++; $display("FAIL start_ball: got %0d want 3", bus.ball); end
        n_tests++; if (bus.gra_still !== 1'b0) begin n_fail++; $display("FAIL start_gra_still: got %b want 0", bus.gra_still); end
        n_tests++; if (bus.text_en !== 4'b1000) begin n_fail++; $display("FAIL start_text_en: got %b want 1000", bus.text_en); end
        bus.btn_start = 1'b0; cyc();
    endtask

    task automatic test_single_score();
        score(1'b1, 1'b0);
        n_tests++; if (bus.dig0 !== 4'd1) begin n_fail++; $display("FAIL p1_dig0: got %0d want 1", bus.dig0); end
        n_tests++; if (bus.ball !== 2'd2) begin n_fail++; $display("FAIL p1_ball: got %0d want 2", bus.ball); end
        n_tests++; if (bus.state !== 2'b10) begin n_fail++; $display("FAIL p1_state: got %b want 10", bus.state); end
        n_tests++; if (bus.gra_still !== 1'b1) begin n_fail++; $display("FAIL p1_gra_still: got %b want 1", bus.gra_still); end
        n_tests++; if (bus.text_en !== 4'b1000) begin n_fail++; $display("FAIL p1_text_en: got %b want 1000", bus.text_en); end
        n_tests++; if (busw.state !== 2'b10) begin n_fail++; $display("FAIL w_first_state: got %b want 10", busw.state); end
        tick_n(50);
        press_start();
        n_tests++; if (bus.state !== 2'b10) begin n_fail++; $display("FAIL early_start_state: got %b want 10", bus.state); end
        tick_n(70);
        bus.btn_start = 1'b1; cyc();
        n_tests++; if (bus.state !== 2'b01) begin n_fail++; $display("FAIL resume_state: got %b want 01", bus.state); end
        n_tests++; if (bus.gra_still !== 1'b0) begin n_fail++; $display("FAIL resume_gra_still: got %b want 0", bus.gra_still); end
        bus.btn_start = 1'b0; cyc();
    endtask

    task automatic test_simultaneous();
        score(1'b1, 1'b1);
        n_tests++; if (bus.dig0 !== 4'd2) begin n_fail++; $display("FAIL both_dig0: got %0d want 2", bus.dig0); end
        n_tests++; if (bus.dig2 !== 4'd1) begin n_fail++; $display("FAIL both_dig2: got %0d want 1", bus.dig2); end
        n_tests++; if (bus.ball !== 2'd1) begin n_fail++; $display("FAIL both_ball: got %0d want 1", bus.ball); end
        n_tests++; if (bus.state !== 2'b10) begin n_fail++; $display("FAIL both_state: got %b want 10", bus.state); end
        n_tests++; if (busw.state !== 2'b11) begin n_fail++; $display("FAIL w_win_state: got %b want 11", busw.state); end
        n_tests++; if (busw.winner !== 2'b01) begin n_fail++; $display("FAIL w_win_winner: got %b want 01", busw.winner); end
        n_tests++; if (busw.text_en !== 4'b1001) begin n_fail++; $display("FAIL w_win_text_en: got %b want 1001", busw.text_en); end
        tick_n(120);
        press_start();
    endtask

    task automatic test_tie_over();
        score(1'b0, 1'b1);
        n_tests++; if (bus.dig2 !== 4'd2) begin n_fail++; $display("FAIL tie_dig2: got %0d want 2", bus.dig2); end
        n_tests++; if (bus.ball !== 2'd0) begin n_fail++; $display("FAIL tie_ball: got %0d want 0", bus.ball); end
        n_tests++; if (bus.state !== 2'b11) begin n_fail++; $display("FAIL tie_state: got %b want 11", bus.state); end
        n_tests++; if (bus.winner !== 2'b11) begin n_fail++; $display("FAIL tie_winner: got %b want 11", bus.winner); end
        n_tests++; if (bus.text_en !== 4'b1001) begin n_fail++; $display("FAIL tie_text_en: got %b want 1001", bus.text_en); end
        tick_n(119);
        n_tests++; if (bus.state !== 2'b11) begin n_fail++; $display("FAIL over_hold_state: got %b want 11", bus.state); end
        tick_n(1);
        n_tests++; if (bus.state !== 2'b00) begin n_fail++; $display("FAIL over_exit_state: got %b want 00", bus.state); end
        n_tests++; if (bus.text_en !== 4'b1110) begin n_fail++; $display("FAIL over_exit_text_en: got %b want 1110", bus.text_en); end
        n_tests++; if ({bus.dig2, bus.dig0} !== 8'h22) begin n_fail++; $display("FAIL over_exit_scores: got %h want 22", {bus.dig2, bus.dig0}); end
        n_tests++; if (bus.winner !== 2'b11) begin n_fail++; $display("FAIL over_exit_winner: got %b want 11", bus.winner); end
    endtask

    task automatic test_hold_and_p1_win();
        press_start();
        n_tests++; if (bus.state !== 2'b01) begin n_fail++; $display("FAIL g2_start_state: got %b want 01", bus.state); end
        n_tests++; if ({bus.dig2, bus.dig0, bus.winner} !== 10'd0) begin n_fail++; $display("FAIL g2_cleared: got %h want 0", {bus.dig2, bus.dig0, bus.winner}); end
        score(1'b1, 1'b0);
        cyc();
        bus.btn_start = 1'b1;
        tick_n(120);
        cyc(); cyc(); cyc();
        n_tests++; if (bus.state !== 2'b10) begin n_fail++; $display("FAIL held_start_state: got %b want 10", bus.state); end
        bus.btn_start = 1'b0; cyc();
        bus.btn_start = 1'b1; cyc();
        n_tests++; if (bus.state !== 2'b01) begin n_fail++; $display("FAIL repress_state: got %b want 01", bus.state); end
        bus.btn_start = 1'b0; cyc();
        score(1'b1, 1'b0);
        tick_n(120);
        press_start();
        score(1'b0, 1'b1);
        n_tests++; if (bus.state !== 2'b11) begin n_fail++; $display("FAIL p1win_state: got %b want 11", bus.state); end
        n_tests++; if (bus.winner !== 2'b01) begin n_fail++; $display("FAIL p1win_winner: got %b want 01", bus.winner); end
        n_tests++; if (bus.text_en !== 4'b1001) begin n_fail++; $display("FAIL p1win_text_en: got %b want 1001", bus.text_en); end
        tick_n(120);
        n_tests++; if (bus.text_en !== 4'b1110) begin n_fail++; $display("FAIL p1win_newgame_text_en: got %b want 1110", bus.text_en); end
        n_tests++; if ({bus.dig2, bus.dig0} !== 8'h12) begin n_fail++; $display("FAIL p1win_scores: got %h want 12", {bus.dig2, bus.dig0}); end
        n_tests++; if (bus.ball !== 2'd0) begin n_fail++; $display("FAIL p1win_ball: got %0d want 0", bus.ball); end
    endtask

    task automatic test_reset_mid_play();
        press_start();
        score(1'b1, 1'b0);
        tick_n(120);
        press_start();
        n_tests++; if ({bus.state, bus.dig0} !== 6'b01_0001) begin n_fail++; $display("FAIL midplay_pre: got %b want 010001", {bus.state, bus.dig0}); end
        #2 reset = 1'b1;
        #1;
        n_tests++; if (bus.state !== 2'b00) begin n_fail++; $display("FAIL async_state: got %b want 00", bus.state); end
        n_tests++; if (bus.dig0 !== 4'd0) begin n_fail++; $display("FAIL async_dig0: got %0d want 0", bus.dig0); end
        n_tests++; if (bus.ball !== 2'd3) begin n_fail++; $display("FAIL async_ball: got %0d want 3", bus.ball); end
        n_tests++; if (bus.gra_still !== 1'b1) begin n_fail++; $display("FAIL async_gra_still: got %b want 1", bus.gra_still); end
        n_tests++; if (bus.text_en !== 4'b1110) begin n_fail++; $display("FAIL async_text_en: got %b want 1110", bus.text_en); end
        cyc();
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_bcd_saturation();
        b_clr = 1'b1; cyc(); b_clr = 1'b0;
        b_inc = 1'b1;
        repeat (9) cyc();
        n_tests++; if ({b_t, b_u} !== 8'h09) begin n_fail++; $display("FAIL bcd_09: got %h want 09", {b_t, b_u}); end
        cyc();
        n_tests++; if ({b_t, b_u} !== 8'h10) begin n_fail++; $display("FAIL bcd_carry: got %h want 10", {b_t, b_u}); end
        repeat (89) cyc();
        n_tests++; if ({b_t, b_u} !== 8'h99) begin n_fail++; $display("FAIL bcd_99: got %h want 99", {b_t, b_u}); end
        cyc();
        n_tests++; if ({b_t, b_u} !== 8'h99) begin n_fail++; $display("FAIL bcd_sat: got %h want 99", {b_t, b_u}); end
        b_inc = 1'b0;
        b_clr = 1'b1; cyc(); b_clr = 1'b0;
        n_tests++; if ({b_t, b_u} !== 8'h00) begin n_fail++; $display("FAIL bcd_clr: got %h want 00", {b_t, b_u}); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_single_score();
        test_simultaneous();
        test_tie_over();
        test_hold_and_p1_win();
        test_reset_mid_play();
        test_bcd_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
